console_arbiter: RTL

//   Shares one byte-wide console output channel between NREQ message sources.

---
 rtl/console_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/console_arbiter.sv
// Round-robin arbiter that shares one byte-wide console channel between NREQ message
// sources, holding each grant for a whole message and truncating runaway messages.
module console_arbiter #(
  parameter int NREQ   = 4,
  parameter int DW     = 8,
  parameter int MAXLEN = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic                     out_last,
  output logic [$clog2(NREQ)-1:0]  out_src,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     trunc_err
);

  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(MAXLEN + 1);

  // Handshake: a beat moves from requester gnt on a cycle where req_valid[gnt] and
  // req_ready[gnt] are both high; a beat leaves on a cycle where out_valid and
  // out_ready are both high. Neither side may retract data while it is offered.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   gnt;
  logic [CW-1:0]   cnt;

  logic [SW-1:0]   pick;
  logic            found;
  int              cand;

  logic            slot_free;
  logic            accept;
  logic [DW-1:0]   cur_data;
  logic            cur_last;
  logic [CW-1:0]   cnt_next;
  logic            hit_max;
  logic            rel;
  logic [SW-1:0]   next_ptr;

  // First requesting index at or after ptr, wrapping past NREQ-1.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = SW'(cand);
      end
    end
  end

  // The output register can take a beat when empty or when it drains this cycle.
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    req_ready = '0;
    if (state == GRANT) begin
      req_ready[gnt] = slot_free;
    end
  end

  assign accept   = (state == GRANT) && req_valid[gnt] && slot_free;
  assign cur_data = req_data[int'(gnt)*DW +: DW];
  assign cur_last = req_last[gnt];
  assign cnt_next = cnt + 1'b1;
  assign hit_max  = (cnt_next == CW'(MAXLEN));
  assign rel      = accept && (cur_last || hit_max);
  assign next_ptr = (gnt == SW'(NREQ - 1)) ? '0 : gnt + 1'b1;

  assign busy = (state == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      trunc_err <= 1'b0;
    end else begin
      trunc_err <= 1'b0;

      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            state <= IDLE;
            ptr   <= next_ptr;
            cnt   <= '0;
          end else if (accept) begin
            cnt <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase

      // A truncated beat is closed as if it carried last, so the sink sees a clean end.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= cur_data;
        out_src   <= gnt;
        out_last  <= cur_last || hit_max;
        trunc_err <= hit_max && !cur_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
